// File: rtl/puc_uart_pkg.sv
// Shared definitions for the register-value UART transmitter.
//   tx_state_t      : transmitter FSM state encoding
//   UART_DATA_BITS  : data bits per serial byte
//   UART_STOP_LEVEL : line level driven during the stop bit
//   uartFrameBits() : serial bits per byte (start + data + [parity] + stop)
// Build option: TX_PARITY_EN adds one even-parity bit per byte.
package puc_uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_STOP_LEVEL = 1'b1;

  function automatic int uartFrameBits();
`ifdef TX_PARITY_EN
    return 11;
`else
    return 10;
`endif
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
//   clock   : rising-edge clock
//   isReset : synchronous active-high reset
//   restart : zero the period counter (aligns bit boundaries to a new frame)
//   tick    : one-cycle pulse every CLKS_PER_BIT cycles after restart
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic isReset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (isReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A restart cycle never ticks, so the first bit always gets its full period.
  assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/reg_value_uart_tx.sv
// Serial transmitter for the CPU's observable register value.
// Accepts a REGISTER_WIDTH word and sends it as 8N1 UART bytes, most
// significant byte first, LSB first within each byte.
//   clock   : rising-edge clock
//   isReset : synchronous active-high reset, overrides everything
//   valueIn : word to transmit, sampled on acceptance
//   valid   : send request
//   ready   : idle; a word is accepted at a posedge with valid & ready
//   txLine  : UART line, idles high
//   busy    : inverse of ready; high from acceptance until the last stop bit ends
// Handshake: valid/ready. A transfer happens only at a posedge where both are
// high. valid need not be held, and valid while busy is dropped, not queued.
// Build option: TX_PARITY_EN inserts an even-parity bit after each byte's data.
module reg_value_uart_tx
  import puc_uart_pkg::*;
#(
  parameter int REGISTER_WIDTH = 8,
  parameter int CLKS_PER_BIT   = 4
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic [REGISTER_WIDTH-1:0] valueIn,
  input  logic                      valid,
  output logic                      ready,
  output logic                      txLine,
  output logic                      busy
);

  localparam int NBYTES = REGISTER_WIDTH / UART_DATA_BITS;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [REGISTER_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]                bit_q, bit_d;
  logic [BYTE_W-1:0]         byte_q, byte_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;

  logic       accept;
  logic       tick;
  logic [7:0] cur_byte;

  assign accept   = valid && ready;
  // The byte on the wire is always the top byte; later bytes are shifted up.
  assign cur_byte = shift_q[REGISTER_WIDTH-1 -: UART_DATA_BITS];

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .isReset(isReset),
    .restart(accept),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      TX_IDLE: begin
        byte_d = '0;
        bit_d  = '0;
        if (accept) begin
          shift_d = valueIn;
          state_d = TX_START;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (tick) begin
          bit_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_d = cur_byte[bit_q];
        if (tick) begin
          if (bit_q == LAST_BIT) begin
`ifdef TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef TX_PARITY_EN
      TX_PARITY: begin
        tx_d = ^cur_byte;
        if (tick) begin
          state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        tx_d = UART_STOP_LEVEL;
        if (tick) begin
          if (byte_q == LAST_BYTE) begin
            state_d = TX_IDLE;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + BYTE_W'(1);
            shift_d = shift_q << UART_DATA_BITS;
            state_d = TX_START;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // txLine is registered from the state, so the line lags the FSM by one
  // cycle: the start bit appears the cycle after acceptance. done_q holds
  // ready low for that same trailing cycle so the last stop bit completes.
  always_ff @(posedge clock) begin
    if (isReset) begin
      state_q <= TX_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign ready  = (state_q == TX_IDLE) && !done_q;
  assign busy   = !ready;
  assign txLine = tx_q;

endmodule

// File: tb/tb_reg_value_uart_tx.sv
// Directed bench for reg_value_uart_tx: an 8-bit and a 16-bit instance share
// clock and reset. Expected line bits are queued per frame and checked every
// cycle, 1 time unit after each rising edge.
module tb_reg_value_uart_tx;

  localparam int CPB = 4;
`ifdef TX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif

  // clock / reset
  logic clock   = 1'b0;
  logic isReset = 1'b1;
  always #5 clock = ~clock;

  logic [7:0]  value8  = 8'h00;
  logic        valid8  = 1'b1;
  logic        ready8, tx8, busy8;
  logic [15:0] value16 = 16'h0000;
  logic        valid16 = 1'b1;
  logic        ready16, tx16, busy16;

  reg_value_uart_tx #(.REGISTER_WIDTH(8), .CLKS_PER_BIT(CPB)) dut8 (
    .clock(clock), .isReset(isReset), .valueIn(value8), .valid(valid8),
    .ready(ready8), .txLine(tx8), .busy(busy8)
  );

  reg_value_uart_tx #(.REGISTER_WIDTH(16), .CLKS_PER_BIT(CPB)) dut16 (
    .clock(clock), .isReset(isReset), .valueIn(value16), .valid(valid16),
    .ready(ready16), .txLine(tx16), .busy(busy16)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? tx16 : tx8;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy16 : busy8;
  endfunction
  function automatic logic ready_of(input int sel);
    return (sel != 0) ? ready16 : ready8;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef TX_PARITY_EN
    exp_q.push_back(^b);
`endif
    exp_q.push_back(1'b1);
  endtask

  // driver tasks: present the word, let the acceptance edge pass, then
  // scramble valueIn to show it is no longer sampled.
  task automatic start8(input logic [7:0] v);
    value8 = v;
    valid8 = 1'b1;
    tick();
    check("acc8_ready", ready8, 0);
    check("acc8_busy", busy8, 1);
    check("acc8_tx_idle", tx8, 1);
    valid8 = 1'b0;
    value8 = ~v;
  endtask

  task automatic start16(input logic [15:0] v);
    value16 = v;
    valid16 = 1'b1;
    tick();
    check("acc16_ready", ready16, 0);
    check("acc16_busy", busy16, 1);
    check("acc16_tx_idle", tx16, 1);
    valid16 = 1'b0;
    value16 = ~v;
  endtask

  // Checks ncheck line cycles starting at acceptance+1. A full frame also
  // checks that ready returns exactly one cycle after the last frame cycle.
  // inject >= 0 pulses valid8 with 8'hFF so it is high at frame cycle inject+1.
  task automatic run_frame(input int sel, input string tag, input int ncheck, input int inject);
    int total;
    total = exp_q.size() * CPB;
    for (int c = 0; c < ncheck; c++) begin
      tick();
      check($sformatf("%s_tx_c%0d", tag, c), tx_of(sel), exp_q[c / CPB]);
      check($sformatf("%s_busy_c%0d", tag, c), busy_of(sel), 1);
      if (c == inject) begin
        valid8 = 1'b1;
        value8 = 8'hFF;
      end else if (c == inject + 1) begin
        valid8 = 1'b0;
      end
    end
    if (ncheck == total) begin
      tick();
      check($sformatf("%s_ready_end", tag), ready_of(sel), 1);
      check($sformatf("%s_busy_end", tag), busy_of(sel), 0);
      check($sformatf("%s_tx_end", tag), tx_of(sel), 1);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      check($sformatf("%s_tx8_c%0d", tag, c), tx8, 1);
      check($sformatf("%s_ready8_c%0d", tag, c), ready8, 1);
      check($sformatf("%s_tx16_c%0d", tag, c), tx16, 1);
    end
  endtask

  initial begin
    // reset held two cycles with valid high on both instances
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_tx8", tx8, 1);
      check("rst_ready8", ready8, 1);
      check("rst_busy8", busy8, 0);
      check("rst_tx16", tx16, 1);
      check("rst_ready16", ready16, 1);
    end
    isReset = 1'b0;
    valid8  = 1'b0;
    valid16 = 1'b0;
    idle_check("post_rst", 6);

    // 8'hA5, hand-written line pattern
    start8(8'hA5);
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef TX_PARITY_EN
    exp_q.push_back(1'b0);
`endif
    exp_q.push_back(1'b1);
    check("a5_frame_bits", exp_q.size(), BITS);
    run_frame(0, "a5", BITS * CPB, -1);
    exp_q.delete();
    idle_check("a5_idle", 3);

    // 16'h1234: two back-to-back bytes, busy over the whole 2-byte frame
    start16(16'h1234);
    push_byte(8'h12);
    push_byte(8'h34);
    run_frame(1, "w1234", 2 * BITS * CPB, -1);
    exp_q.delete();

    // 8'h00 with a valid pulse of 8'hFF at frame cycle 10: must be ignored
    start8(8'h00);
    push_byte(8'h00);
    run_frame(0, "ign00", BITS * CPB, 9);
    exp_q.delete();
    idle_check("ign_idle", 2 * BITS * CPB);

    // 8'h01 (parity bit 1 when parity is enabled)
    start8(8'h01);
    push_byte(8'h01);
    run_frame(0, "b01", BITS * CPB, -1);
    exp_q.delete();

    // reset at frame cycle 15 of an 8'hA5 frame
    start8(8'hA5);
    push_byte(8'hA5);
    run_frame(0, "abort", 15, -1);
    exp_q.delete();
    isReset = 1'b1;
    tick();
    check("abort_tx", tx8, 1);
    check("abort_ready", ready8, 1);
    check("abort_busy", busy8, 0);
    isReset = 1'b0;
    idle_check("abort_idle", 8);

    // clean frame after the abort
    start8(8'h3C);
    push_byte(8'h3C);
    run_frame(0, "c3c", BITS * CPB, -1);
    exp_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
